// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU opcode table and RV32I major-opcode constants used by
//             the issue stage and the ALU itself.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Datapath width the decode tables are written for
    localparam int XLEN = 32;

    // ALU opcode table (bit 3 groups logic/compare ops, bit 2 groups shifts)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // funct7 encodings: base form and the "alternate" form (SUB / SRA / SRAI)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 encodings shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage_if
//  Brief    : Upstream (fetch/regfile-read) and downstream (execute) handshake
//             bundle of the ALU issue stage. "slave" is the stage's view,
//             "master" is the view of the logic surrounding it.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    // upstream side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    // downstream side
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_alu_op;
    logic [DATA_W-1:0] out_a_data;
    logic [DATA_W-1:0] out_b_data;
    logic [4:0]        out_rd;
    logic              out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_alu_op, out_a_data, out_b_data, out_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_alu_op, out_a_data, out_b_data, out_rd, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Brief    : Combinational RV32I decode of OP, OP-IMM, LUI and AUIPC into the
//             ALU opcode and operand pair. Anything else is flagged illegal and
//             presented as ADD 0,0 so a passed-through illegal entry is inert.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       i_inst,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    output logic [3:0]        o_alu_op,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [4:0]        o_rd,
    output logic              o_illegal
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic              w_alt;
    logic [DATA_W-1:0] w_imm_i;
    logic [DATA_W-1:0] w_imm_sh;
    logic [DATA_W-1:0] w_imm_u;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_ill;

    // A full 7-bit opcode compare also rejects inst[1:0] != 2'b11
    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];
    assign w_alt    = (w_funct7 == F7_ALT);
    assign w_imm_i  = {{(DATA_W-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_sh = {{(DATA_W-5){1'b0}}, i_inst[24:20]};
    assign w_imm_u  = {i_inst[31:12], {(DATA_W-20){1'b0}}};
    assign o_rd     = i_inst[11:7];

    // Raw decode; funct7 legality is resolved per instruction class
    always_comb begin
        w_op  = ALU_ADD;
        w_a   = '0;
        w_b   = '0;
        w_ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a = i_rs1;
                w_b = i_rs2;
                case (w_funct3)
                    F3_ADD:  w_op = w_alt ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_op = ALU_SLL;
                    F3_SLT:  w_op = ALU_SLT;
                    F3_SLTU: w_op = ALU_SLTU;
                    F3_XOR:  w_op = ALU_XOR;
                    F3_SR:   w_op = w_alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_op = ALU_OR;
                    F3_AND:  w_op = ALU_AND;
                    default: w_op = ALU_ADD;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form
                w_ill = !((w_funct7 == F7_BASE) ||
                          (w_alt && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR))));
            end
            OPC_OPIMM: begin
                w_a = i_rs1;
                w_b = w_imm_i;
                case (w_funct3)
                    F3_ADD:  w_op = ALU_ADD;
                    F3_SLT:  w_op = ALU_SLT;
                    F3_SLTU: w_op = ALU_SLTU;
                    F3_XOR:  w_op = ALU_XOR;
                    F3_OR:   w_op = ALU_OR;
                    F3_AND:  w_op = ALU_AND;
                    F3_SLL: begin
                        w_op  = ALU_SLL;
                        w_b   = w_imm_sh;
                        w_ill = (w_funct7 != F7_BASE);
                    end
                    F3_SR: begin
                        w_op  = w_alt ? ALU_SRA : ALU_SRL;
                        w_b   = w_imm_sh;
                        w_ill = !((w_funct7 == F7_BASE) || w_alt);
                    end
                    default: w_op = ALU_ADD;
                endcase
            end
            OPC_LUI: begin
                w_b = w_imm_u;
            end
            OPC_AUIPC: begin
                w_a = i_pc;
                w_b = w_imm_u;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // Illegal entries are squashed to ADD 0,0
    always_comb begin
        o_illegal = w_ill;
        o_alu_op  = w_ill ? ALU_ADD : w_op;
        o_a       = w_ill ? '0 : w_a;
        o_b       = w_ill ? '0 : w_b;
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Brief    : Registered decode/issue stage in front of the ALU. Decoded
//             entries sit in an output register (OUT) backed by a one-entry
//             skid register (SKID) so that the registered in_ready can lag
//             downstream back-pressure by a cycle without losing anything.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W       = 32,   // only 32 is supported
    parameter bit ILLEGAL_PASS = 1'b1  // 0: illegal entries are consumed silently
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.slave   bus
);

    // Payload layout: {alu_op, a, b, rd, illegal}
    localparam int PAY_W = 4 + DATA_W + DATA_W + 5 + 1;

    logic [3:0]        w_dec_op;
    logic [DATA_W-1:0] w_dec_a;
    logic [DATA_W-1:0] w_dec_b;
    logic [4:0]        w_dec_rd;
    logic              w_dec_illegal;
    logic [PAY_W-1:0]  w_dec_pay;

    logic              r_out_valid;
    logic [PAY_W-1:0]  r_out_pay;
    logic              r_skid_valid;
    logic [PAY_W-1:0]  r_skid_pay;
    logic              r_in_ready;

    logic              w_in_fire;
    logic              w_load;
    logic              w_out_free;
    logic              w_out_valid_nxt;
    logic              w_skid_valid_nxt;
    logic              w_out_from_skid;
    logic              w_out_from_in;
    logic              w_skid_from_in;

    alu_op_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .i_inst    (bus.in_inst),
        .i_pc      (bus.in_pc),
        .i_rs1     (bus.in_rs1_data),
        .i_rs2     (bus.in_rs2_data),
        .o_alu_op  (w_dec_op),
        .o_a       (w_dec_a),
        .o_b       (w_dec_b),
        .o_rd      (w_dec_rd),
        .o_illegal (w_dec_illegal)
    );

    assign w_dec_pay = {w_dec_op, w_dec_a, w_dec_b, w_dec_rd, w_dec_illegal};

    // A handshake always consumes the input; only kept entries occupy storage
    assign w_in_fire  = bus.in_valid && r_in_ready;
    assign w_load     = w_in_fire && (ILLEGAL_PASS || !w_dec_illegal);
    // OUT can take a new entry when it is empty or being drained this cycle
    assign w_out_free = !r_out_valid || bus.out_ready;

    // Occupancy update and data steering; flush overrides everything.
    // SKID can only be full while in_ready is low, so a load never meets a
    // full SKID.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_out_from_skid  = 1'b0;
        w_out_from_in    = 1'b0;
        w_skid_from_in   = 1'b0;
        if (bus.flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
                w_out_from_skid  = 1'b1;
            end else if (w_load) begin
                w_out_valid_nxt  = 1'b1;
                w_out_from_in    = 1'b1;
            end else begin
                w_out_valid_nxt  = 1'b0;
            end
        end else if (w_load) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_from_in   = 1'b1;
        end
    end

    // OUT/SKID storage and registered in_ready. in_ready is held low while
    // reset is asserted and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_pay    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_out_from_skid) begin
                r_out_pay <= r_skid_pay;
            end else if (w_out_from_in) begin
                r_out_pay <= w_dec_pay;
            end
            if (w_skid_from_in) begin
                r_skid_pay <= w_dec_pay;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign {bus.out_alu_op, bus.out_a_data, bus.out_b_data, bus.out_rd, bus.out_illegal} = r_out_pay;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Brief    : Self-checking bench for alu_issue_stage: decode vector table,
//             hand-written back-pressure / flush / reset / illegal-drop
//             sequences, and a randomized run against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(32)) bus  ();
    alu_issue_stage_if #(.DATA_W(32)) bus0 ();

    alu_issue_stage #(.DATA_W(32), .ILLEGAL_PASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu_issue_stage #(.DATA_W(32), .ILLEGAL_PASS(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, "_op"},  32'(bus.out_alu_op),  32'(e.op));
        check({tag, "_a"},   bus.out_a_data,       e.a);
        check({tag, "_b"},   bus.out_b_data,       e.b);
        check({tag, "_rd"},  32'(bus.out_rd),      32'(e.rd));
        check({tag, "_ill"}, 32'(bus.out_illegal), 32'(e.ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, pc, rs1, rs2);
        bus.in_valid    = v;
        bus.in_inst     = inst;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
    endtask

    function automatic vec_t mk(input logic [31:0] inst, pc, rs1, rs2, input logic [3:0] op,
                                input logic [31:0] a, b, input logic [4:0] rd, input logic ill);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.e.op = op; v.e.a = a; v.e.b = b; v.e.rd = rd; v.e.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] add_rd(input logic [4:0] rd);
        return 32'h00208033 | (32'(rd) << 7);
    endfunction

    // Reference decode by instruction mask/match, as an ISA manual lists them
    function automatic exp_t ref_decode(input logic [31:0] inst, pc, rs1, rs2);
        exp_t e;
        int kind;  // 0 none, 1 reg-reg, 2 reg-imm, 3 reg-shamt, 4 lui, 5 auipc
        kind = 0;
        e.op = 4'h0; e.a = 32'h0; e.b = 32'h0; e.rd = inst[11:7]; e.ill = 1'b1;
        case (inst & 32'hFE00707F)
            32'h00000033: begin kind = 1; e.op = 4'b0000; end
            32'h40000033: begin kind = 1; e.op = 4'b0001; end
            32'h00001033: begin kind = 1; e.op = 4'b0100; end
            32'h00002033: begin kind = 1; e.op = 4'b1101; end
            32'h00003033: begin kind = 1; e.op = 4'b1100; end
            32'h00004033: begin kind = 1; e.op = 4'b1011; end
            32'h00005033: begin kind = 1; e.op = 4'b0110; end
            32'h40005033: begin kind = 1; e.op = 4'b0111; end
            32'h00006033: begin kind = 1; e.op = 4'b1010; end
            32'h00007033: begin kind = 1; e.op = 4'b1001; end
            32'h00001013: begin kind = 3; e.op = 4'b0100; end
            32'h00005013: begin kind = 3; e.op = 4'b0110; end
            32'h40005013: begin kind = 3; e.op = 4'b0111; end
            default: ;
        endcase
        if (kind == 0) begin
            case (inst & 32'h0000707F)
                32'h00000013: begin kind = 2; e.op = 4'b0000; end
                32'h00002013: begin kind = 2; e.op = 4'b1101; end
                32'h00003013: begin kind = 2; e.op = 4'b1100; end
                32'h00004013: begin kind = 2; e.op = 4'b1011; end
                32'h00006013: begin kind = 2; e.op = 4'b1010; end
                32'h00007013: begin kind = 2; e.op = 4'b1001; end
                default: ;
            endcase
        end
        if (kind == 0) begin
            case (inst & 32'h0000007F)
                32'h00000037: kind = 4;
                32'h00000017: kind = 5;
                default: ;
            endcase
        end
        case (kind)
            1: begin e.a = rs1;   e.b = rs2; end
            2: begin e.a = rs1;   e.b = $signed(inst) >>> 20; end
            3: begin e.a = rs1;   e.b = 32'(inst[24:20]); end
            4: begin e.a = 32'h0; e.b = inst & 32'hFFFFF000; end
            5: begin e.a = pc;    e.b = inst & 32'hFFFFF000; end
            default: ;
        endcase
        e.ill = (kind == 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  f7;
        int          sel;
        int          f7sel;
        w     = $urandom();
        sel   = $urandom_range(0, 9);
        f7sel = $urandom_range(0, 3);
        f7    = (f7sel < 2) ? 7'h00 : (f7sel == 2) ? 7'h20 : 7'($urandom_range(0, 127));
        case (sel)
            0, 1, 2: w = {f7, w[24:7], 7'b0110011};
            3, 4, 5: w = {f7, w[24:7], 7'b0010011};
            6:       w = {w[31:7], 7'b0110111};
            7:       w = {w[31:7], 7'b0010111};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        vec_t        tbl[$];
        exp_t        q[$];
        logic        hold;
        logic        in_fire;
        logic        out_fire;

        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        bus0.flush       = 1'b0;
        bus0.out_ready   = 1'b0;
        bus0.in_valid    = 1'b0;
        bus0.in_inst     = 32'h0;
        bus0.in_pc       = 32'h0;
        bus0.in_rs1_data = 32'h0;
        bus0.in_rs2_data = 32'h0;

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_alu_op",    32'(bus.out_alu_op), 32'h0);
        check("rst_a",         bus.out_a_data, 32'h0);
        check("rst_b",         bus.out_b_data, 32'h0);
        check("rst_rd",        32'(bus.out_rd), 32'h0);
        check("rst_illegal",   32'(bus.out_illegal), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready_after_edge", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid_after",     32'(bus.out_valid), 32'h0);

        // ---------------- decode vector table ----------------
        tbl.push_back(mk(32'h002081B3, 32'h40, 5, 7, 4'b0000, 5, 7, 3, 0));
        tbl.push_back(mk(32'h402081B3, 32'h40, 5, 7, 4'b0001, 5, 7, 3, 0));
        tbl.push_back(mk(32'h002091B3, 32'h40, 5, 7, 4'b0100, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020A1B3, 32'h40, 5, 7, 4'b1101, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020B1B3, 32'h40, 5, 7, 4'b1100, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020C1B3, 32'h40, 5, 7, 4'b1011, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020D1B3, 32'h40, 5, 7, 4'b0110, 5, 7, 3, 0));
        tbl.push_back(mk(32'h4020D1B3, 32'h40, 5, 7, 4'b0111, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020E1B3, 32'h40, 5, 7, 4'b1010, 5, 7, 3, 0));
        tbl.push_back(mk(32'h0020F1B3, 32'h40, 5, 7, 4'b1001, 5, 7, 3, 0));
        tbl.push_back(mk(32'h40435293, 32'h40, 32'h80000000, 7, 4'b0111, 32'h80000000, 4, 5, 0));
        tbl.push_back(mk(32'h42435293, 32'h40, 32'h80000000, 7, 4'b0000, 0, 0, 5, 1));
        tbl.push_back(mk(32'h12345097, 32'h100, 5, 7, 4'b0000, 32'h100, 32'h12345000, 1, 0));
        tbl.push_back(mk(32'hABCDE537, 32'h40, 5, 7, 4'b0000, 0, 32'hABCDE000, 10, 0));
        tbl.push_back(mk(32'hFFF00093, 32'h40, 5, 7, 4'b0000, 5, 32'hFFFFFFFF, 1, 0));
        tbl.push_back(mk(32'h0050B113, 32'h40, 5, 7, 4'b1100, 5, 5, 2, 0));
        tbl.push_back(mk(32'h01F31293, 32'h40, 5, 7, 4'b0100, 5, 31, 5, 0));
        tbl.push_back(mk(32'h41F31293, 32'h40, 5, 7, 4'b0000, 0, 0, 5, 1));
        tbl.push_back(mk(32'h40209133, 32'h40, 5, 7, 4'b0000, 0, 0, 2, 1));
        tbl.push_back(mk(32'h022081B3, 32'h40, 5, 7, 4'b0000, 0, 0, 3, 1));
        tbl.push_back(mk(32'h002081B0, 32'h40, 5, 7, 4'b0000, 0, 0, 3, 1));
        tbl.push_back(mk(32'h0000007F, 32'h40, 5, 7, 4'b0000, 0, 0, 0, 1));

        bus.out_ready = 1'b1;
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk); #1;
            drive(1'b1, tbl[k].inst, tbl[k].pc, tbl[k].rs1, tbl[k].rs2);
            @(posedge clk); #1;
            drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", k), 32'(bus.out_valid), 32'h1);
            check_out($sformatf("vec%0d", k), tbl[k].e);
        end
        @(posedge clk);
        @(negedge clk);
        check("vec_drained", 32'(bus.out_valid), 32'h0);

        // ---------------- back-pressure: 2 held, 3rd waits ----------------
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, add_rd(5'd1), 32'h0, 32'd1, 32'd1);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd2), 32'h0, 32'd2, 32'd2);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd3), 32'h0, 32'd3, 32'd3);
        @(negedge clk);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'h0);
        check("bp_out_valid",     32'(bus.out_valid), 32'h1);
        check("bp_head_rd",       32'(bus.out_rd), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_rd",       32'(bus.out_rd), 32'd1);
        check("bp_hold_a",        bus.out_a_data, 32'd1);
        check("bp_hold_in_ready", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_second_rd",     32'(bus.out_rd), 32'd2);
        check("bp_second_valid",  32'(bus.out_valid), 32'h1);
        check("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1 drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("bp_third_rd",      32'(bus.out_rd), 32'd3);
        check("bp_third_valid",   32'(bus.out_valid), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("bp_empty",         32'(bus.out_valid), 32'h0);

        // ---------------- flush with OUT+SKID full and in_valid=1 ----------------
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, add_rd(5'd4), 32'h0, 32'd4, 32'd4);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd5), 32'h0, 32'd5, 32'd5);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd6), 32'h0, 32'd6, 32'd6);
        @(negedge clk);
        check("fl_full_in_ready", 32'(bus.in_ready), 32'h0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("fl_out_valid",     32'(bus.out_valid), 32'h0);
        check("fl_in_ready",      32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fl_stays_empty%0d", k), 32'(bus.out_valid), 32'h0);
        end

        // ---------------- flush drops an input accepted in the same cycle ----------------
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, add_rd(5'd7), 32'h0, 32'd7, 32'd7);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd8), 32'h0, 32'd8, 32'd8);
        @(negedge clk);
        check("fl2_in_ready_open", 32'(bus.in_ready), 32'h1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fl2_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        check("fl2_no_ghost",  32'(bus.out_valid), 32'h0);

        // ---------------- asynchronous reset mid-stall ----------------
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 32'h12345097, 32'h100, 32'd9, 32'd9);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd10), 32'h0, 32'd10, 32'd10);
        @(posedge clk); #1 drive(1'b1, add_rd(5'd11), 32'h0, 32'd11, 32'd11);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'h0);
        check("ar_alu_op",    32'(bus.out_alu_op), 32'h0);
        check("ar_a",         bus.out_a_data, 32'h0);
        check("ar_b",         bus.out_b_data, 32'h0);
        check("ar_rd",        32'(bus.out_rd), 32'h0);
        check("ar_illegal",   32'(bus.out_illegal), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ar_in_ready_after", 32'(bus.in_ready), 32'h1);
        check("ar_empty_after",    32'(bus.out_valid), 32'h0);

        // ---------------- ILLEGAL_PASS=0: illegal consumed, legal follows ----------------
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b1;
        bus0.in_inst  = 32'h0000007F;
        @(posedge clk); #1;
        bus0.in_inst  = add_rd(5'd9);
        @(negedge clk);
        check("ip0_dropped_valid", 32'(bus0.out_valid), 32'h0);
        check("ip0_in_ready",      32'(bus0.in_ready), 32'h1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("ip0_legal_valid",   32'(bus0.out_valid), 32'h1);
        check("ip0_legal_rd",      32'(bus0.out_rd), 32'd9);
        @(negedge clk);
        check("ip0_empty",         32'(bus0.out_valid), 32'h0);

        // ---------------- randomized run against queue model ----------------
        q.delete();
        hold = 1'b0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            if (!hold) begin
                drive(($urandom_range(0, 9) < 7), rand_inst(), $urandom(), $urandom(), $urandom());
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            check("rnd_in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
            check("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (bus.out_valid && (q.size() > 0)) check_out("rnd", q[0]);
            in_fire  = bus.in_valid && (q.size() < 2);
            out_fire = (q.size() > 0) && bus.out_ready;
            if (out_fire) void'(q.pop_front());
            if (bus.flush) q.delete();
            else if (in_fire) q.push_back(ref_decode(bus.in_inst, bus.in_pc, bus.in_rs1_data, bus.in_rs2_data));
            hold = bus.in_valid && !in_fire;
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
